// File: rtl/seg_pkg.sv
// seg_pkg: glyph constants, capture FSM state type and the segment-to-hex
// decode helper shared by the seg_scan_capture block.
package seg_pkg;

    // Active-low segment patterns, bit6=g .. bit0=a.
    localparam logic [6:0] GLYPH_0   = 7'b1000000;
    localparam logic [6:0] GLYPH_1   = 7'b1111001;
    localparam logic [6:0] GLYPH_2   = 7'b0100100;
    localparam logic [6:0] GLYPH_3   = 7'b0110000;
    localparam logic [6:0] GLYPH_4   = 7'b0011001;
    localparam logic [6:0] GLYPH_5   = 7'b0010010;
    localparam logic [6:0] GLYPH_6   = 7'b0000010;
    localparam logic [6:0] GLYPH_7   = 7'b1111000;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0010000;
    localparam logic [6:0] GLYPH_A   = 7'b0001000;
    localparam logic [6:0] GLYPH_B   = 7'b0000011;
    localparam logic [6:0] GLYPH_C   = 7'b1000110;
    localparam logic [6:0] GLYPH_D   = 7'b0100001;
    localparam logic [6:0] GLYPH_E   = 7'b0000110;
    localparam logic [6:0] GLYPH_F   = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        WAIT,
        COUNT,
        COMMIT,
        HOLD
    } scan_state_e;

    // Returns {legal, hex}; legal=0 means the pattern is no known glyph.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'h00;
        case (seg)
            GLYPH_0: res = 5'h10;
            GLYPH_1: res = 5'h11;
            GLYPH_2: res = 5'h12;
            GLYPH_3: res = 5'h13;
            GLYPH_4: res = 5'h14;
            GLYPH_5: res = 5'h15;
            GLYPH_6: res = 5'h16;
            GLYPH_7: res = 5'h17;
            GLYPH_8: res = 5'h18;
            GLYPH_9: res = 5'h19;
            GLYPH_A: res = 5'h1A;
            GLYPH_B: res = 5'h1B;
            GLYPH_C: res = 5'h1C;
            GLYPH_D: res = 5'h1D;
            GLYPH_E: res = 5'h1E;
            GLYPH_F: res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_capture_sync.sv
// seg_sync: parameterized-width two-flop synchronizer; both stages preset to
// all-ones so the active-low bus reads as idle out of reset.
module seg_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments let both stages sample their old values on
    // the same edge; blocking here would collapse the chain into one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: decodes a multiplexed active-low 7-segment bus back into
// per-digit hex values. Define SEG_DP_EN to also capture the decimal point.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
`ifdef SEG_DP_EN
    input  logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd,
    output logic [2:0]              upd_idx,
    output logic                    code_err,
    output logic                    err_sticky
);

`ifdef SEG_DP_EN
    localparam int DP_W = 1;
`else
    localparam int DP_W = 0;
`endif
    localparam int SW = DP_W + NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CYCLES);

    // Sample layout: {[dp,] dig, seg}; compared as one word for stability.
    logic [SW-1:0] raw_bus;
    logic [SW-1:0] samp;

`ifdef SEG_DP_EN
    assign raw_bus = {dp_n, dig_n, seg_n};
`else
    assign raw_bus = {dig_n, seg_n};
`endif

    seg_sync #(.WIDTH(SW)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_bus),
        .q   (samp)
    );

    logic [NUM_DIGITS-1:0] samp_act;
    logic                  samp_single;

    assign samp_act    = ~samp[7 +: NUM_DIGITS];
    assign samp_single = (samp_act != '0) &&
                         ((samp_act & (samp_act - 1'b1)) == '0);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] ref_q, ref_d;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        case (state_q)
            WAIT: begin
                if (samp_single) begin
                    ref_d   = samp;
                    cnt_d   = CW'(1);
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (samp == ref_q) begin
                    if (cnt_q != CNT_DONE) cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_DONE) state_d = COMMIT;
                end else if (samp_single) begin
                    ref_d = samp;
                    cnt_d = CW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            COMMIT: begin
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                // A change re-arms immediately, exactly as WAIT would.
                if (samp != ref_q) begin
                    if (samp_single) begin
                        ref_d   = samp;
                        cnt_d   = CW'(1);
                        state_d = COUNT;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            ref_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
        end
    end

    logic [NUM_DIGITS-1:0] ref_act;
    logic [4:0]            dec;
    logic                  dec_legal;
    logic                  ref_blank;

    assign ref_act   = ~ref_q[7 +: NUM_DIGITS];
    assign dec       = seg_to_hex(ref_q[6:0]);
    assign dec_legal = dec[4];
    assign ref_blank = (ref_q[6:0] == SEG_BLANK);

    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    upd_q, upd_d;
    logic [2:0]              idx_q, idx_d;
    logic                    err_q, err_d;
    logic                    sticky_q, sticky_d;
`ifdef SEG_DP_EN
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
`endif

    always_comb begin
        hex_d    = hex_q;
        valid_d  = valid_q;
        upd_d    = 1'b0;
        idx_d    = idx_q;
        err_d    = 1'b0;
        sticky_d = sticky_q;
`ifdef SEG_DP_EN
        dp_d     = dp_q;
`endif
        if (state_q == COMMIT) begin
            upd_d = 1'b1;
            if (!dec_legal && !ref_blank) begin
                err_d    = 1'b1;
                sticky_d = 1'b1;
            end
            // The reference is one-hot, so exactly one digit slot is touched.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (ref_act[i]) begin
                    idx_d      = 3'(i);
                    valid_d[i] = dec_legal;
                    if (dec_legal) hex_d[4*i +: 4] = dec[3:0];
`ifdef SEG_DP_EN
                    if (dec_legal || ref_blank) dp_d[i] = ~ref_q[SW-1];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_q    <= '0;
            valid_q  <= '0;
            upd_q    <= 1'b0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
`ifdef SEG_DP_EN
            dp_q     <= '0;
`endif
        end else begin
            hex_q    <= hex_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
`ifdef SEG_DP_EN
            dp_q     <= dp_d;
`endif
        end
    end

    assign hex_out     = hex_q;
    assign digit_valid = valid_q;
    assign upd         = upd_q;
    assign upd_idx     = idx_q;
    assign code_err    = err_q;
    assign err_sticky  = sticky_q;
`ifdef SEG_DP_EN
    assign dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed latency/scan/glitch/error
// sequences, a vector table, and random scans against a run-length model.
module tb_seg_scan_capture;

    localparam int ND = 4;
    localparam int SC = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      seg_n = 7'h7F;
    logic [ND-1:0]   dig_n = '1;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0]   digit_valid;
    logic            upd;
    logic [2:0]      upd_idx;
    logic            code_err;
    logic            err_sticky;
`ifdef SEG_DP_EN
    logic            dp_n = 1'b1;
    logic [ND-1:0]   dp_out;
`endif

    always #5 clk = ~clk;

    seg_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
`ifdef SEG_DP_EN
        .dp_n        (dp_n),
        .dp_out      (dp_out),
`endif
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .upd         (upd),
        .upd_idx     (upd_idx),
        .code_err    (code_err),
        .err_sticky  (err_sticky)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent glyph table, index = hex value.
    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [2:0] idx;
        logic       err;
        logic [3:0] nib;
        logic       vld;
    } commit_t;

    typedef struct {
        logic [ND-1:0] dig;
        logic [6:0]    seg;
        int            idx;
        logic [3:0]    nib;
        logic          vld;
        logic          err;
    } vec_t;

    commit_t    exp_q [$];
    logic [2:0] idx_log [$];
    bit         rand_mode = 1'b0;
    int         cyc = 0;
    int         upd_cnt = 0;
    int         err_cnt = 0;
    int         last_upd_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        commit_t e;
        if (upd === 1'b1) begin
            upd_cnt++;
            last_upd_cyc = cyc;
            idx_log.push_back(upd_idx);
            if (code_err === 1'b1) err_cnt++;
            if (rand_mode) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_upd", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_upd_idx", 32'(upd_idx), 32'(e.idx));
                    check("rand_code_err", 32'(code_err), 32'(e.err));
                    check("rand_hex_nib", 32'(hex_out[4*e.idx +: 4]), 32'(e.nib));
                    check("rand_valid_bit", 32'(digit_valid[e.idx]), 32'(e.vld));
                end
            end
        end else if (code_err === 1'b1) begin
            check("code_err_without_upd", 32'd1, 32'd0);
        end
    end

    // Drive pins at a negedge and keep them for n rising edges.
    task automatic hold(input logic [ND-1:0] d, input logic [6:0] s, input int n);
        @(negedge clk);
        dig_n = d;
        seg_n = s;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hex"}, 32'(hex_out), 32'd0);
        check({tag, "_valid"}, 32'(digit_valid), 32'd0);
        check({tag, "_upd"}, 32'(upd), 32'd0);
        check({tag, "_idx"}, 32'(upd_idx), 32'd0);
        check({tag, "_code_err"}, 32'(code_err), 32'd0);
        check({tag, "_sticky"}, 32'(err_sticky), 32'd0);
`ifdef SEG_DP_EN
        check({tag, "_dp_out"}, 32'(dp_out), 32'd0);
`endif
    endtask

    vec_t          vecs [12];
    logic [3:0]    m_hex [ND];
    logic [ND-1:0] m_vld;
    logic          m_sticky;

    initial begin
        int u0, e0, t0;
        logic [4*ND-1:0] m_word;
        logic [ND-1:0]   pd;
        logic [6:0]      ps;

        vecs[0]  = '{4'b1110, 7'b1111000, 0, 4'h7, 1'b1, 1'b0};
        vecs[1]  = '{4'b1101, 7'b0010000, 1, 4'h9, 1'b1, 1'b0};
        vecs[2]  = '{4'b1011, 7'b0000011, 2, 4'hB, 1'b1, 1'b0};
        vecs[3]  = '{4'b0111, 7'b1000110, 3, 4'hC, 1'b1, 1'b0};
        vecs[4]  = '{4'b1110, 7'b0100001, 0, 4'hD, 1'b1, 1'b0};
        vecs[5]  = '{4'b1101, 7'b0000110, 1, 4'hE, 1'b1, 1'b0};
        vecs[6]  = '{4'b1011, 7'b0000010, 2, 4'h6, 1'b1, 1'b0};
        vecs[7]  = '{4'b0111, 7'b0011001, 3, 4'h4, 1'b1, 1'b0};
        vecs[8]  = '{4'b0111, 7'b1111111, 3, 4'h4, 1'b0, 1'b0};
        vecs[9]  = '{4'b1110, 7'b0000001, 0, 4'hD, 1'b0, 1'b1};
        vecs[10] = '{4'b1101, 7'b1000000, 1, 4'h0, 1'b1, 1'b0};
        vecs[11] = '{4'b1011, 7'b0000000, 2, 4'h8, 1'b1, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        hold('1, 7'h7F, 3);

        // Latency: pins steady from edge N give upd at N+2+SC, once.
        u0 = upd_cnt;
        @(negedge clk);
        dig_n = 4'b1110;
        seg_n = 7'b0110000;
        t0 = cyc + 1;
        repeat (19) @(negedge clk);
        check("lat_upd_count", 32'(upd_cnt - u0), 32'd1);
        check("lat_cycle", 32'(last_upd_cyc - t0), 32'(2 + SC));
        check("lat_idx", 32'(idx_log[idx_log.size() - 1]), 32'd0);
        check("lat_hex0", 32'(hex_out[3:0]), 32'h3);
        check("lat_valid", 32'(digit_valid), 32'b0001);

        // Four-digit scan.
        u0 = upd_cnt;
        idx_log.delete();
        hold(4'b1110, glyph_tab[1], 16);
        hold(4'b1101, glyph_tab[2], 16);
        hold(4'b1011, glyph_tab[10], 16);
        hold(4'b0111, glyph_tab[15], 16);
        hold('1, 7'h7F, 4);
        check("scan_upd_count", 32'(upd_cnt - u0), 32'd4);
        check("scan_hex", 32'(hex_out), 32'hFA21);
        check("scan_valid", 32'(digit_valid), 32'hF);
        for (int i = 0; i < 4; i++) begin
            if (i < idx_log.size()) check("scan_idx", 32'(idx_log[i]), 32'(i));
            else check("scan_idx_missing", 32'(idx_log.size()), 32'd4);
        end

        // Short glitch to '8' must not commit.
        u0 = upd_cnt;
        hold(4'b1101, 7'b0100100, 14);
        hold(4'b1101, 7'b0000000, 3);
        hold(4'b1101, 7'b0100100, 14);
        hold('1, 7'h7F, 2);
        check("glitch_upd_count", 32'(upd_cnt - u0), 32'd2);
        check("glitch_hex1", 32'(hex_out[7:4]), 32'h2);

        // Illegal pattern then blank on digit 2.
        u0 = upd_cnt;
        e0 = err_cnt;
        hold(4'b1011, 7'b1010101, 14);
        hold('1, 7'h7F, 2);
        check("err_upd_count", 32'(upd_cnt - u0), 32'd1);
        check("err_pulses", 32'(err_cnt - e0), 32'd1);
        check("err_sticky", 32'(err_sticky), 32'd1);
        check("err_valid2", 32'(digit_valid[2]), 32'd0);
        check("err_hex2", 32'(hex_out[11:8]), 32'hA);
        u0 = upd_cnt;
        e0 = err_cnt;
        hold(4'b1011, 7'b1111111, 14);
        hold('1, 7'h7F, 2);
        check("blank_upd_count", 32'(upd_cnt - u0), 32'd1);
        check("blank_err_pulses", 32'(err_cnt - e0), 32'd0);
        check("blank_valid2", 32'(digit_valid[2]), 32'd0);
        check("blank_hex2", 32'(hex_out[11:8]), 32'hA);
        check("blank_sticky_kept", 32'(err_sticky), 32'd1);

        // Two digits enabled: nothing selected.
        u0 = upd_cnt;
        hold(4'b1100, 7'b0110000, 30);
        check("multi_upd_count", 32'(upd_cnt - u0), 32'd0);

        // Reset in the fifth COUNT cycle discards the pending sample.
        u0 = upd_cnt;
        hold(4'b1110, 7'b0010010, 7);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        dig_n = '1;
        seg_n = 7'h7F;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold('1, 7'h7F, 20);
        check("midrst_upd_count", 32'(upd_cnt - u0), 32'd0);
        check("midrst_valid", 32'(digit_valid), 32'd0);

        // Vector table.
        foreach (vecs[v]) begin
            u0 = upd_cnt;
            e0 = err_cnt;
            hold(vecs[v].dig, vecs[v].seg, 14);
            hold('1, 7'h7F, 2);
            check($sformatf("vec%0d_upd_count", v), 32'(upd_cnt - u0), 32'd1);
            check($sformatf("vec%0d_idx", v), 32'(idx_log[idx_log.size() - 1]), 32'(vecs[v].idx));
            check($sformatf("vec%0d_hex", v), 32'(hex_out[4*vecs[v].idx +: 4]), 32'(vecs[v].nib));
            check($sformatf("vec%0d_valid", v), 32'(digit_valid[vecs[v].idx]), 32'(vecs[v].vld));
            check($sformatf("vec%0d_err", v), 32'(err_cnt - e0), 32'(vecs[v].err));
        end

`ifdef SEG_DP_EN
        // Decimal point capture and dp-only recommit.
        dp_n = 1'b0;
        u0 = upd_cnt;
        hold(4'b1110, glyph_tab[5], 14);
        check("dp_hex0", 32'(hex_out[3:0]), 32'h5);
        check("dp_out0_set", 32'(dp_out[0]), 32'd1);
        @(negedge clk);
        dp_n = 1'b1;
        repeat (13) @(negedge clk);
        check("dp_upd_count", 32'(upd_cnt - u0), 32'd2);
        check("dp_out0_clr", 32'(dp_out[0]), 32'd0);
        hold('1, 7'h7F, 2);
`endif

        // Random scans against a run-length model, from a clean reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold('1, 7'h7F, 3);
        for (int i = 0; i < ND; i++) m_hex[i] = 4'h0;
        m_vld    = '0;
        m_sticky = 1'b0;
        pd       = '1;
        ps       = 7'h7F;
        rand_mode = 1'b1;
        for (int k = 0; k < 80; k++) begin
            logic [ND-1:0] d;
            logic [6:0]    s;
            int            n, r, gi, di;
            commit_t       e;
            do begin
                r = $urandom_range(0, 9);
                if (r < 7)       d = ~(ND'(1) << $urandom_range(0, ND - 1));
                else if (r == 7) d = '1;
                else             d = ND'($urandom);
                r = $urandom_range(0, 9);
                if (r < 7)       s = glyph_tab[$urandom_range(0, 15)];
                else if (r == 7) s = 7'h7F;
                else             s = 7'($urandom);
            end while (d == pd && s == ps);
            n = ($urandom_range(0, 1) == 1) ? $urandom_range(1, SC - 1)
                                            : $urandom_range(SC + 1, SC + 8);
            // A single-digit pattern held for at least SC samples commits once.
            if ($countones(~d) == 1 && n >= SC) begin
                di = 0;
                for (int j = 0; j < ND; j++) if (!d[j]) di = j;
                gi = -1;
                for (int g = 0; g < 16; g++) if (s == glyph_tab[g]) gi = g;
                e.err = 1'b0;
                if (gi >= 0) begin
                    m_hex[di] = 4'(gi);
                    m_vld[di] = 1'b1;
                end else begin
                    m_vld[di] = 1'b0;
                    if (s != 7'h7F) begin
                        e.err    = 1'b1;
                        m_sticky = 1'b1;
                    end
                end
                e.idx = 3'(di);
                e.nib = m_hex[di];
                e.vld = m_vld[di];
                exp_q.push_back(e);
            end
            hold(d, s, n);
            pd = d;
            ps = s;
        end
        hold('1, 7'h7F, 20);
        rand_mode = 1'b0;
        for (int i = 0; i < ND; i++) m_word[4*i +: 4] = m_hex[i];
        check("rand_pending_commits", 32'(exp_q.size()), 32'd0);
        check("rand_final_hex", 32'(hex_out), 32'(m_word));
        check("rand_final_valid", 32'(digit_valid), 32'(m_vld));
        check("rand_final_sticky", 32'(err_sticky), 32'(m_sticky));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Reverse path of the team's hex-to-segment display decode.
- Samples an externally driven, time-multiplexed, active-low 7-segment bus (segment lines plus digit enables), waits for each pattern to settle, and decodes it back to a 4-bit hex value per digit.
- Used to read back board displays and to self-check our own display drivers on the FPGA.
- Outputs a registered hex word, per-digit valid bits, an update strobe and error reporting.

Parameters:
- NUM_DIGITS, 4: number of digit-enable lines and captured digits (1..8).
- STABLE_CYCLES, 8: consecutive identical synchronized samples required before commit (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- seg_n  in  7  segment lines, active-low, bit6=g .. bit0=a, asynchronous to clk
- dig_n  in  NUM_DIGITS  digit enables, active-low, asynchronous to clk
- hex_out  out  4*NUM_DIGITS  captured digits; digit i at [4i+3:4i]
- digit_valid  out  NUM_DIGITS  digit i holds a decoded hex value
- upd  out  1  one-cycle pulse on every commit
- upd_idx  out  3  digit index of the current commit; valid while upd=1
- code_err  out  1  one-cycle pulse when a committed pattern is not a legal glyph
- err_sticky  out  1  set by code_err; cleared only by rst

Behaviour:
- Reset (async, rst=1):
  - hex_out=0, digit_valid=0, upd=0, upd_idx=0, code_err=0, err_sticky=0.
  - Synchronizers preset to all-ones (inactive).
  - FSM to WAIT, stability counter 0.
  - Reset asserted mid-capture discards the pending sample; no commit.
- Synchronization: seg_n and dig_n each pass through a 2-flop synchronizer. All logic below uses the synchronized sample S = {dig, seg}.
- Single-digit condition: exactly one dig bit low. Zero or multiple low bits means no digit is selected.
- FSM states:
  - WAIT: no digit selected. On a single-digit sample, latch S as the reference, set cnt=1, go to COUNT.
  - COUNT:
    - S equals the reference: cnt++.
    - When cnt reaches STABLE_CYCLES: go to COMMIT.
    - S differs and is single-digit: re-latch the reference, cnt=1, stay in COUNT.
    - S has no digit selected: go to WAIT.
  - COMMIT (one cycle): update the output registers for the reference digit index k, then go to HOLD.
  - HOLD: stay while S equals the reference. On any change, behave exactly as WAIT does with the new sample, in the same cycle. A digit is therefore committed once per scan visit, not repeatedly.
- Commit actions, based on the reference segment pattern:
  - Legal glyph:
    - hex_out[k] = decoded value, digit_valid[k]=1.
    - Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, c=1000110, d=0100001, E=0000110, F=0001110.
  - Blank 1111111: digit_valid[k]=0, hex_out[k] unchanged, no error.
  - Any other pattern: digit_valid[k]=0, hex_out[k] unchanged, code_err=1, err_sticky=1.
  - upd=1 and upd_idx=k on every commit, including blank and error commits.
- Latency: pins held steady from clock edge N (first sampled edge) give upd high in cycle N+2+STABLE_CYCLES.
- Glitch rejection: any change shorter than STABLE_CYCLES synchronized samples never commits.
- Other digits' registers are untouched by a commit.
- No wrap: cnt saturates at STABLE_CYCLES; the counter is wide enough for STABLE_CYCLES.

Optional Feature:
- Macro: SEG_DP_EN.
- Defined:
  - Adds input dp_n (1 bit, active-low, synchronized with seg_n and part of the reference/compare) and output dp_out (NUM_DIGITS).
  - dp_out[k] = ~dp_n on a legal-glyph or blank commit.
  - dp_n alone changing restarts COUNT.
  - dp_out resets to 0.
- Undefined: no dp port; behaviour as above.

Decomposition:
- Package seg_pkg holds:
  - the 16 glyph constants;
  - SEG_BLANK = 7'b1111111;
  - the FSM state enum (WAIT, COUNT, COMMIT, HOLD);
  - a function seg_to_hex returning {legal, hex[3:0]}.
- One sub-module: seg_sync, a parameterized-width 2-flop synchronizer with reset-to-ones, instantiated for the seg/dig(/dp) bus.

Test Plan:
- Reset then drive dig_n=1110, seg_n=0110000 for 20 cycles -> single upd at cycle N+10 (STABLE_CYCLES=8), upd_idx=0, hex_out[3:0]=3, digit_valid=0001; no further upd while held.
- Scan four digits 1,2,A,F on dig_n 1110/1101/1011/0111 at 16 cycles each -> hex_out=16'hFA21, digit_valid=1111, four upd pulses with idx 0..3.
- Digit 1 stable with seg_n=0100100, one 3-cycle glitch to 0000000 -> no commit of 8; final commit hex 2.
- seg_n=1010101 held on digit 2 -> code_err pulse, err_sticky=1, digit_valid[2]=0, hex_out[2] unchanged; blank 1111111 on digit 2 -> upd, no error, digit_valid[2]=0.
- dig_n=1100 (two active) held 30 cycles -> no upd; assert rst at cycle 5 of a COUNT run -> all outputs 0, no commit.
- With SEG_DP_EN: digit 0 glyph 5 with dp_n=0 -> hex 5, dp_out[0]=1; toggling dp_n alone recommits after STABLE_CYCLES.
